// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 8086 minimum-mode bus bridge.
package cpu_bus_pkg;

  // Bus-cycle tracking states of the bridge
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    REQ  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } bus_state_t;

  // Both byte lanes disabled: an impossible transfer on the 8086 bus
  localparam logic [1:0]  BE_NONE     = 2'b00;
  // Read data returned to the CPU when the target never answers
  localparam logic [15:0] RD_ERR_DATA = 16'hFFFF;

  // Word address A19:1; the I/O space has no A19:16, so those bits read as zero
  function automatic logic [18:0] word_addr(input logic       is_mem,
                                            input logic [3:0]  a_hi,
                                            input logic [15:0] a_lo);
    return {(is_mem ? a_hi : 4'h0), a_lo[15:1]};
  endfunction

  // Byte lanes {high, low}: high lane from BHE#, low lane when the address is even
  function automatic logic [1:0] byte_en(input logic bhe_n, input logic a0);
    return {~bhe_n, ~a0};
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Down-counter with load, enable and terminal-count flag.
// The bridge shares one instance between the target timeout and the READY hold-off.
module bus_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Load has priority; counting stops at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/cpu_bus_bridge.sv
// Demultiplexes the minimum-mode 8086 bus into a single-request target port
// and returns read data and READY to the CPU. All outputs are registered.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MIN_WAIT       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic        m_ioN,
  input  logic        rdN,
  input  logic        wrN,
  input  logic        bheN,
  input  logic        denN,
  input  logic        dt_rN,
  input  logic [3:0]  asbus,
  input  logic [15:0] adbus_in,
  output logic [15:0] adbus_out,
  output logic        adbus_oe,
  output logic        ready,
  output logic        tgt_req,
  output logic        tgt_io,
  output logic        tgt_we,
  output logic [18:0] tgt_addr,
  output logic [1:0]  tgt_be,
  output logic [15:0] tgt_wdata,
  input  logic [15:0] tgt_rdata,
  input  logic        tgt_ack,
  output logic        bus_err
);

  // Counter preloads: REQ lasts at most TIMEOUT_CYCLES, HOLD lasts MIN_WAIT+1 cycles
  localparam logic [15:0] W_TO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] W_MW_LOAD = 16'(MIN_WAIT);

  bus_state_t  r_state, w_state_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_req,   w_req_nxt;
  logic        r_io,    w_io_nxt;
  logic        r_we,    w_we_nxt;
  logic [18:0] r_addr,  w_addr_nxt;
  logic [1:0]  r_be,    w_be_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [15:0] r_out,   w_out_nxt;
  logic        r_oe,    w_oe_nxt;
  logic        r_err,   w_err_nxt;
  logic [15:0] r_hold,  w_hold_nxt;
  logic        r_pend,  w_pend_nxt;
  logic        w_latch;
  logic        w_cnt_load;
  logic [15:0] w_cnt_val;
  logic        w_cnt_en;
  logic        w_cnt_tc;

  bus_timeout_ctr #(.W(16)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_tc       (w_cnt_tc)
  );

  // Next-state and next-output decode for the bus-cycle tracker
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_req_nxt   = r_req;
    w_io_nxt    = r_io;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_be_nxt    = r_be;
    w_wdata_nxt = r_wdata;
    w_out_nxt   = r_out;
    w_oe_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_hold_nxt  = r_hold;
    w_pend_nxt  = r_pend;
    w_latch     = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_en    = 1'b0;

    if (ale && (r_state != IDLE)) begin
      // A new ALE mid-cycle kills the current cycle; its address is kept so the
      // IDLE pass on the next clock starts the new cycle even if ALE has dropped.
      w_latch     = 1'b1;
      w_req_nxt   = 1'b0;
      w_ready_nxt = 1'b1;
      w_err_nxt   = 1'b1;
      w_pend_nxt  = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_pend_nxt = 1'b0;
          if (ale) begin
            w_latch     = 1'b1;
            w_ready_nxt = 1'b0;
            w_state_nxt = ADDR;
          end else if (r_pend) begin
            w_ready_nxt = 1'b0;
            w_state_nxt = ADDR;
          end
        end
        ADDR: begin
          if (!rdN || !wrN) begin
            // Read wins when both strobes are low
            w_we_nxt = rdN;
            if (r_be == BE_NONE) begin
              w_err_nxt   = 1'b1;
              w_ready_nxt = 1'b1;
              w_hold_nxt  = RD_ERR_DATA;
              w_state_nxt = DONE;
            end else begin
              if (rdN) w_wdata_nxt = adbus_in;
              if (!rdN && !wrN) w_err_nxt = 1'b1;
              w_req_nxt   = 1'b1;
              w_cnt_load  = 1'b1;
              w_cnt_val   = W_TO_LOAD;
              w_state_nxt = REQ;
            end
          end
        end
        REQ: begin
          if (tgt_ack) begin
            w_req_nxt   = 1'b0;
            if (!r_we) w_hold_nxt = tgt_rdata;
            w_cnt_load  = 1'b1;
            w_cnt_val   = W_MW_LOAD;
            w_state_nxt = HOLD;
          end else if (w_cnt_tc) begin
            w_req_nxt   = 1'b0;
            w_hold_nxt  = RD_ERR_DATA;
            w_err_nxt   = 1'b1;
            w_cnt_load  = 1'b1;
            w_cnt_val   = W_MW_LOAD;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        HOLD: begin
          if (w_cnt_tc) begin
            w_ready_nxt = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
        DONE: begin
          w_out_nxt = r_hold;
          if (rdN && wrN) begin
            w_state_nxt = IDLE;
          end else begin
            w_oe_nxt = ~r_we & ~rdN & ~denN & ~dt_rN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end

    if (w_latch) begin
      w_io_nxt   = ~m_ioN;
      w_addr_nxt = word_addr(m_ioN, asbus, adbus_in);
      w_be_nxt   = byte_en(bheN, adbus_in[0]);
    end
  end

  // State and output registers; reset returns every output to its idle value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_req   <= 1'b0;
      r_io    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_out   <= '0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_req   <= w_req_nxt;
      r_io    <= w_io_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_be    <= w_be_nxt;
      r_wdata <= w_wdata_nxt;
      r_out   <= w_out_nxt;
      r_oe    <= w_oe_nxt;
      r_err   <= w_err_nxt;
      r_hold  <= w_hold_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign ready     = r_ready;
  assign tgt_req   = r_req;
  assign tgt_io    = r_io;
  assign tgt_we    = r_we;
  assign tgt_addr  = r_addr;
  assign tgt_be    = r_be;
  assign tgt_wdata = r_wdata;
  assign adbus_out = r_out;
  assign adbus_oe  = r_oe;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: a bus-cycle model checked every cycle,
// plus literal expectations for the main bus transactions.
module tb_cpu_bus_bridge;

  localparam int TO = 8;
  localparam int MW = 2;

  logic        clk;
  logic        reset;
  logic        ale, m_ioN, rdN, wrN, bheN, denN, dt_rN;
  logic [3:0]  asbus;
  logic [15:0] adbus_in;
  logic [15:0] adbus_out;
  logic        adbus_oe, ready, tgt_req, tgt_io, tgt_we;
  logic [18:0] tgt_addr;
  logic [1:0]  tgt_be;
  logic [15:0] tgt_wdata;
  logic [15:0] tgt_rdata;
  logic        tgt_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_err    = 0;

  cpu_bus_bridge #(.TIMEOUT_CYCLES(TO), .MIN_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .ale(ale), .m_ioN(m_ioN), .rdN(rdN), .wrN(wrN),
    .bheN(bheN), .denN(denN), .dt_rN(dt_rN), .asbus(asbus), .adbus_in(adbus_in),
    .adbus_out(adbus_out), .adbus_oe(adbus_oe), .ready(ready), .tgt_req(tgt_req),
    .tgt_io(tgt_io), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_be(tgt_be),
    .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus-cycle model ----------------
  localparam int PH_IDLE = 0, PH_WAIT_STROBE = 1, PH_TARGET = 2, PH_READY_DELAY = 3, PH_DATA = 4;

  bit          mv = 1'b0;
  int          ph = PH_IDLE;
  bit          m_pend;
  int          req_age, hold_age;
  logic        e_ready, e_req, e_io, e_we, e_err, e_oe;
  logic [18:0] e_addr;
  logic [1:0]  e_be;
  logic [15:0] e_wdata, e_out, m_hold;

  task automatic capture_address();
    e_io   = !m_ioN;
    e_addr = m_ioN ? {asbus, adbus_in[15:1]} : {4'h0, adbus_in[15:1]};
    e_be   = {!bheN, !adbus_in[0]};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        ph = PH_IDLE; m_pend = 1'b0; req_age = 0; hold_age = 0;
        e_ready = 1'b1; e_req = 1'b0; e_io = 1'b0; e_we = 1'b0; e_err = 1'b0; e_oe = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0; e_out = '0; m_hold = '0;
      end else begin
        e_err = 1'b0;
        e_oe  = 1'b0;
        if (ale && ph != PH_IDLE) begin
          capture_address();
          e_req = 1'b0; e_ready = 1'b1; e_err = 1'b1; m_pend = 1'b1; ph = PH_IDLE;
        end else if (ph == PH_IDLE) begin
          if (ale) begin
            capture_address();
            e_ready = 1'b0; ph = PH_WAIT_STROBE;
          end else if (m_pend) begin
            e_ready = 1'b0; ph = PH_WAIT_STROBE;
          end
          m_pend = 1'b0;
        end else if (ph == PH_WAIT_STROBE) begin
          if (!rdN || !wrN) begin
            e_we = rdN;
            if (e_be == 2'b00) begin
              e_err = 1'b1; e_ready = 1'b1; m_hold = 16'hFFFF; ph = PH_DATA;
            end else begin
              if (rdN) e_wdata = adbus_in;
              e_err   = !rdN && !wrN;
              e_req   = 1'b1;
              req_age = 0;
              ph      = PH_TARGET;
            end
          end
        end else if (ph == PH_TARGET) begin
          req_age++;
          if (tgt_ack) begin
            e_req = 1'b0;
            if (!e_we) m_hold = tgt_rdata;
            hold_age = 0; ph = PH_READY_DELAY;
          end else if (req_age == TO) begin
            e_req = 1'b0; m_hold = 16'hFFFF; e_err = 1'b1;
            hold_age = 0; ph = PH_READY_DELAY;
          end
        end else if (ph == PH_READY_DELAY) begin
          hold_age++;
          if (hold_age == MW + 1) begin
            e_ready = 1'b1; ph = PH_DATA;
          end
        end else begin
          e_out = m_hold;
          if (rdN && wrN) ph = PH_IDLE;
          else e_oe = !e_we && !rdN && !denN && !dt_rN;
        end
      end
      mv = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        chk("ready",     32'(ready),     32'(e_ready));
        chk("tgt_req",   32'(tgt_req),   32'(e_req));
        chk("tgt_io",    32'(tgt_io),    32'(e_io));
        chk("tgt_we",    32'(tgt_we),    32'(e_we));
        chk("tgt_addr",  32'(tgt_addr),  32'(e_addr));
        chk("tgt_be",    32'(tgt_be),    32'(e_be));
        chk("tgt_wdata", 32'(tgt_wdata), 32'(e_wdata));
        chk("adbus_out", 32'(adbus_out), 32'(e_out));
        chk("adbus_oe",  32'(adbus_oe),  32'(e_oe));
        chk("bus_err",   32'(bus_err),   32'(e_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_ale(input logic mio, input logic bhe, input logic [19:0] a);
    ale = 1'b1; m_ioN = mio; bheN = bhe; asbus = a[19:16]; adbus_in = a[15:0];
    step();
    ale = 1'b0; adbus_in = 16'h0000;
  endtask

  task automatic rd_strobe(input logic on);
    rdN = !on; denN = !on; dt_rN = !on;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ale = 1'b0; m_ioN = 1'b1; rdN = 1'b1; wrN = 1'b1; bheN = 1'b1;
    denN = 1'b1; dt_rN = 1'b1; asbus = 4'h0; adbus_in = 16'h0000;
    tgt_rdata = 16'h0000; tgt_ack = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_req",   32'(tgt_req), 32'd0);
    chk("rst_addr",  32'(tgt_addr), 32'd0);
    chk("rst_oe",    32'(adbus_oe), 32'd0);
    reset = 1'b0;
    step();

    // Memory word read 0x12344, ack after three request cycles
    put_ale(1'b1, 1'b0, 20'h12344);
    chk("t1_ready_low", 32'(ready), 32'd0);
    rd_strobe(1'b1);
    step();
    chk("t1_req",  32'(tgt_req),  32'd1);
    chk("t1_addr", 32'(tgt_addr), 32'h091A2);
    chk("t1_be",   32'(tgt_be),   32'h3);
    chk("t1_we",   32'(tgt_we),   32'd0);
    step(); step();
    tgt_ack = 1'b1; tgt_rdata = 16'hBEEF;
    step();
    tgt_ack = 1'b0; tgt_rdata = 16'h0000;
    chk("t1_req_drop", 32'(tgt_req), 32'd0);
    wait_ready(n);
    chk("t1_ready_wait", 32'(n), 32'(MW + 1));
    step();
    chk("t1_rdata", 32'(adbus_out), 32'hBEEF);
    chk("t1_oe",    32'(adbus_oe),  32'd1);
    rd_strobe(1'b0);
    step();
    chk("t1_oe_off", 32'(adbus_oe), 32'd0);
    step();

    // I/O byte write to odd port 0x0061
    put_ale(1'b0, 1'b0, 20'h00061);
    wrN = 1'b0; denN = 1'b0; dt_rN = 1'b1; adbus_in = 16'h00A5;
    step();
    adbus_in = 16'h0000;
    chk("t2_io",    32'(tgt_io),    32'd1);
    chk("t2_addr",  32'(tgt_addr),  32'h0030);
    chk("t2_be",    32'(tgt_be),    32'h2);
    chk("t2_we",    32'(tgt_we),    32'd1);
    chk("t2_wdata", 32'(tgt_wdata), 32'h00A5);
    tgt_ack = 1'b1;
    step();
    tgt_ack = 1'b0;
    wait_ready(n);
    chk("t2_ready_wait", 32'(n), 32'(MW + 1));
    wrN = 1'b1; denN = 1'b1;
    step(); step();

    // Odd-byte memory read at 0x00001
    put_ale(1'b1, 1'b0, 20'h00001);
    rd_strobe(1'b1);
    step();
    chk("t3_be",   32'(tgt_be),   32'h2);
    chk("t3_addr", 32'(tgt_addr), 32'h0);
    tgt_ack = 1'b1; tgt_rdata = 16'h5A00;
    step();
    tgt_ack = 1'b0;
    wait_ready(n);
    step();
    chk("t3_rdata", 32'(adbus_out), 32'h5A00);
    rd_strobe(1'b0);
    step(); step();

    // No acknowledge: timeout after TO request cycles
    put_ale(1'b1, 1'b0, 20'h00400);
    rd_strobe(1'b1);
    step();
    n = 0;
    while (tgt_req === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t4_req_len", 32'(n), 32'(TO));
    chk("t4_err",     32'(bus_err), 32'd1);
    step();
    chk("t4_err_pulse", 32'(bus_err), 32'd0);
    wait_ready(n);
    step();
    chk("t4_rdata", 32'(adbus_out), 32'hFFFF);
    chk("t4_oe",    32'(adbus_oe),  32'd1);
    chk("t4_ready", 32'(ready),     32'd1);
    rd_strobe(1'b0);
    step(); step();

    // ALE reasserted while the target request is pending
    put_ale(1'b1, 1'b0, 20'h01000);
    rd_strobe(1'b1);
    step(); step();
    rd_strobe(1'b0);
    put_ale(1'b1, 1'b0, 20'h02002);
    chk("t5_err",   32'(bus_err),  32'd1);
    chk("t5_req",   32'(tgt_req),  32'd0);
    chk("t5_addr",  32'(tgt_addr), 32'h01001);
    step();
    chk("t5_restart", 32'(ready), 32'd0);
    rd_strobe(1'b1);
    step();
    chk("t5_req2", 32'(tgt_req), 32'd1);
    tgt_ack = 1'b1; tgt_rdata = 16'h1234;
    step();
    tgt_ack = 1'b0;
    wait_ready(n);
    step();
    chk("t5_rdata", 32'(adbus_out), 32'h1234);
    rd_strobe(1'b0);
    step(); step();

    // Reset during a pending request, with an acknowledge that must be ignored
    put_ale(1'b1, 1'b0, 20'h00800);
    rd_strobe(1'b1);
    step();
    chk("t6_req", 32'(tgt_req), 32'd1);
    reset = 1'b1; tgt_ack = 1'b1; tgt_rdata = 16'h7777;
    step();
    chk("t6_req_rst",   32'(tgt_req), 32'd0);
    chk("t6_ready_rst", 32'(ready),   32'd1);
    reset = 1'b0;
    step();
    chk("t6_stray_ack", 32'(tgt_req), 32'd0);
    tgt_ack = 1'b0;
    rd_strobe(1'b0);
    step();

    // Odd address with BHE# high: no byte lanes, no request
    put_ale(1'b1, 1'b1, 20'h00003);
    chk("t7_be", 32'(tgt_be), 32'h0);
    rd_strobe(1'b1);
    step();
    chk("t7_err",   32'(bus_err), 32'd1);
    chk("t7_noreq", 32'(tgt_req), 32'd0);
    chk("t7_ready", 32'(ready),   32'd1);
    step();
    chk("t7_rdata", 32'(adbus_out), 32'hFFFF);
    rd_strobe(1'b0);
    step(); step();

    // Both strobes low: read wins and an error is flagged
    put_ale(1'b1, 1'b0, 20'h00010);
    rd_strobe(1'b1); wrN = 1'b0;
    step();
    chk("t8_err", 32'(bus_err), 32'd1);
    chk("t8_req", 32'(tgt_req), 32'd1);
    chk("t8_we",  32'(tgt_we),  32'd0);
    tgt_ack = 1'b1; tgt_rdata = 16'h0F0F;
    step();
    tgt_ack = 1'b0;
    wait_ready(n);
    rd_strobe(1'b0); wrN = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
